// File: rtl/alu_pkg.sv
// Shared definitions for the ALU self-test: opcodes, LFSR taps, FSM encoding.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SRL = 3'd4;
  localparam logic [2:0] OP_SRA = 3'd5;
  localparam int         NUM_OPS = 6;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/alu_ref.sv
// Combinational golden model of the ALU; opcodes 6 and 7 are unused and yield zero.
module alu_ref
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] c
);

  // Select the reference result for the requested opcode.
  always_comb begin
    c = 32'h0;
    case (op)
      OP_ADD: c = a + b;
      OP_SUB: c = a - b;
      OP_AND: c = a & b;
      OP_OR:  c = a | b;
      OP_SRL: c = a >> b[4:0];
      OP_SRA: c = $unsigned($signed(a) >>> b[4:0]);
      default: c = 32'h0;
    endcase
  end

endmodule

// File: rtl/alu_bist.sv
// Built-in self-test controller for an external combinational ALU.
// Each vector takes two cycles: DRIVE registers operands and the golden
// result, CHECK compares the ALU output against it.
// Optional macro ALU_BIST_STOP_ON_FAIL_EN: end the run at the first mismatch.
module alu_bist
  import alu_pkg::*;
#(
  parameter int          NUM_VEC = 64,
  parameter logic [31:0] SEED    = 32'hACE1_2468,
  parameter int          ERR_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [31:0]      alu_A,
  output logic [31:0]      alu_B,
  output logic [2:0]       alu_ALUOp,
  input  logic [31:0]      alu_C,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      first_fail_idx
);

  localparam logic [15:0] LAST_IDX = 16'(NUM_VEC - 1);
  localparam logic [2:0]  LAST_OP  = 3'(NUM_OPS - 1);

  state_t      state, state_n;
  logic [31:0] lfsr;
  logic [15:0] idx;
  logic [2:0]  op_cnt;   // tracks idx mod 6 without a divider
  logic [31:0] exp_c;
  logic [31:0] vec_b;
  logic [31:0] ref_c;
  logic        mismatch;
  logic        last;
  logic        stop;

  assign vec_b    = {lfsr[15:0], lfsr[31:16]};
  assign mismatch = (alu_C != exp_c);
  assign last     = (idx == LAST_IDX);
`ifdef ALU_BIST_STOP_ON_FAIL_EN
  assign stop     = last || mismatch;
`else
  assign stop     = last;
`endif

  alu_ref u_ref (
    .a  (lfsr),
    .b  (vec_b),
    .op (op_cnt),
    .c  (ref_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state logic; start is only looked at in IDLE and DONE.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (start) state_n = ST_DRIVE;
      ST_DRIVE: state_n = ST_CHECK;
      ST_CHECK: state_n = stop ? ST_DONE : ST_DRIVE;
      ST_DONE:  if (start) state_n = ST_DRIVE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Datapath: run init, vector drive, result check and error bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_A          <= '0;
      alu_B          <= '0;
      alu_ALUOp      <= '0;
      err_count      <= '0;
      first_fail_idx <= 16'hFFFF;
      lfsr           <= SEED;
      idx            <= '0;
      op_cnt         <= '0;
      exp_c          <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            err_count      <= '0;
            first_fail_idx <= 16'hFFFF;
            lfsr           <= SEED;
            idx            <= '0;
            op_cnt         <= '0;
          end
        end
        ST_DRIVE: begin
          alu_A     <= lfsr;
          alu_B     <= vec_b;
          alu_ALUOp <= op_cnt;
          exp_c     <= ref_c;
          lfsr      <= lfsr_next(lfsr);
        end
        ST_CHECK: begin
          if (mismatch) begin
            if (err_count != {ERR_W{1'b1}}) err_count <= err_count + ERR_W'(1);
            if (first_fail_idx == 16'hFFFF) first_fail_idx <= idx;
          end
          if (!last) begin
            idx    <= idx + 16'd1;
            op_cnt <= (op_cnt == LAST_OP) ? 3'd0 : op_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ST_DRIVE) || (state == ST_CHECK);
  assign done = (state == ST_DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: a behavioural ALU (with selectable faults)
// answers the DUT, and a spec-level model predicts vectors and results.
module tb_alu_bist;

  localparam int          NA    = 12;
  localparam logic [31:0] SEEDA = 32'h8000_0001;
  localparam int          NB    = 60;
  localparam logic [31:0] SEEDB = 32'hACE1_2468;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [31:0] a_A, a_B, a_C, b_A, b_B, b_C;
  logic [2:0]  a_op, b_op;
  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [7:0]  err_a;
  logic [3:0]  err_b;
  logic [15:0] ffi_a, ffi_b;
  int          mode_a = 0;

  int n_chk = 0;
  int n_fail = 0;

  // Expected run description from the model.
  logic [31:0] q_a[$], q_b[$];
  logic [2:0]  q_op[$];
  int          m_err, m_ffi, m_len;

  always #5 clk = ~clk;

  alu_bist #(.NUM_VEC(NA), .SEED(SEEDA), .ERR_W(8)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .alu_A(a_A), .alu_B(a_B), .alu_ALUOp(a_op), .alu_C(a_C),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_fail_idx(ffi_a)
  );

  alu_bist #(.NUM_VEC(NB), .SEED(SEEDB), .ERR_W(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .alu_A(b_A), .alu_B(b_B), .alu_ALUOp(b_op), .alu_C(b_C),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_fail_idx(ffi_b)
  );

  // Behavioural ALU. fault 1: arithmetic shift behaves as logical; fault 2: C[0] stuck at 0.
  function automatic logic [31:0] alu_beh(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input int fault);
    logic [31:0] r;
    int sh;
    sh = int'(b % 32);
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a >> sh;
      3'd5: begin
        r = a >> sh;
        if (a[31] && fault != 1)
          for (int i = 0; i < sh; i++) r[31-i] = 1'b1;
      end
      default: r = 32'h0;
    endcase
    if (fault == 2) r[0] = 1'b0;
    return r;
  endfunction

  assign a_C = alu_beh(a_A, a_B, a_op, mode_a);
  assign b_C = alu_beh(b_A, b_B, b_op, 2);

  // Predict the vector stream and the outcome of one run against a faulty ALU.
  task automatic build_model(input int n, input logic [31:0] seed, input int fault, input int errw);
    logic [31:0] s, a, b;
    logic [2:0]  op;
    int          cnt;
    q_a.delete(); q_b.delete(); q_op.delete();
    s = seed; cnt = 0; m_ffi = 16'hFFFF; m_len = n;
    for (int i = 0; i < n; i++) begin
      a  = s;
      b  = {s[15:0], s[31:16]};
      op = 3'(i % 6);
      q_a.push_back(a); q_b.push_back(b); q_op.push_back(op);
      if (alu_beh(a, b, op, fault) != alu_beh(a, b, op, 0)) begin
        cnt++;
        if (m_ffi == 16'hFFFF) m_ffi = i;
`ifdef ALU_BIST_STOP_ON_FAIL_EN
        m_len = i + 1;
        break;
`endif
      end
      s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    end
    m_err = (cnt > (1 << errw) - 1) ? (1 << errw) - 1 : cnt;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One run of dut_a; repulse>0 pulses start again in that cycle of the run.
  task automatic run_a(input int repulse);
    int busy_n, done_k, v;
    build_model(NA, SEEDA, mode_a, 8);
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    chk("start_busy", 32'(busy_a), 32'd1);
    chk("start_done_clr", 32'(done_a), 32'd0);
    busy_n = 0; done_k = 0;
    for (int k = 1; k <= 200; k++) begin
      if (k > 1) @(negedge clk);
      start_a = (k == repulse);
      if (busy_a) busy_n++;
      v = k / 2 - 1;
      if (k % 2 == 0 && v < m_len) begin
        chk($sformatf("vecA[%0d]", v), a_A, q_a[v]);
        chk($sformatf("vecB[%0d]", v), a_B, q_b[v]);
        chk($sformatf("vecOp[%0d]", v), 32'(a_op), 32'(q_op[v]));
      end
      if (done_a) begin done_k = k; break; end
    end
    start_a = 1'b0;
    chk("run_len", done_k, 2 * m_len + 1);
    chk("busy_cycles", busy_n, 2 * m_len);
    chk("err_count", 32'(err_a), m_err);
    chk("first_fail", 32'(ffi_a), m_ffi);
    chk("pass", 32'(pass_a), (m_err == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_A"}, a_A, 32'h0);
    chk({tag, "_B"}, a_B, 32'h0);
    chk({tag, "_op"}, 32'(a_op), 32'h0);
    chk({tag, "_busy"}, 32'(busy_a), 32'h0);
    chk({tag, "_done"}, 32'(done_a), 32'h0);
    chk({tag, "_pass"}, 32'(pass_a), 32'h0);
    chk({tag, "_err"}, 32'(err_a), 32'h0);
    chk({tag, "_ffi"}, 32'(ffi_a), 32'hFFFF);
  endtask

  initial begin
    int done_k;

    // Reset held with start asserted.
    reset = 1'b1; start_a = 1'b1; start_b = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    chk("reset_busy_b", 32'(busy_b), 32'h0);
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy_a), 32'h0);

    // Correct ALU: full run, pass.
    mode_a = 0;
    run_a(0);
    repeat (3) @(negedge clk);
    chk("done_held", 32'(done_a), 32'd1);
    chk("hold_A", a_A, q_a[NA-1]);
    chk("hold_op", 32'(a_op), 32'(q_op[NA-1]));

    // Faulty SRA, start re-pulsed mid-run, then rerun from DONE.
    mode_a = 1;
    run_a(7);
    run_a(0);

    // Reset during CHECK of vector 3, then a clean rerun.
    mode_a = 0;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_abort_busy", 32'(busy_a), 32'd1);
    chk("pre_abort_A", a_A, q_a[3]);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("abort");
    reset = 1'b0;
    @(negedge clk);
    run_a(0);

    // Stuck-at C[0] on a long run with a narrow error counter.
    build_model(NB, SEEDB, 2, 4);
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    done_k = 0;
    for (int k = 1; k <= 400; k++) begin
      if (k > 1) @(negedge clk);
      if (done_b) begin done_k = k; break; end
    end
    chk("sat_len", done_k, 2 * m_len + 1);
    chk("sat_err", 32'(err_b), m_err);
    chk("sat_ffi", 32'(ffi_b), m_ffi);
    chk("sat_pass", 32'(pass_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
